seq_shifter: RTL and testbench

Multi-cycle, parametrised barrel-shift replacement for the ALU shift path. It performs logical right, arithmetic right, logical left and rotate right on a WIDTH-bit operand. It shifts STEP bits per clock under a start/busy/done handshake, so wide operands cost iterations rather than a full combinational barrel. The result is registered and held until the next operation completes.

---
 rtl/seq_shifter.sv | 155 +++++++++++++++
 tb/tb_seq_shifter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (LSR/ASR/LSL/ROR) moving up to STEP bits per clock under a start/busy/done handshake.
// Define SEQ_SHIFTER_CARRY_EN to build the carry_out logic; otherwise carry_out is tied to 0.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SAW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SAW-1:0]   shift_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] M_LSR = 2'd0;
  localparam logic [1:0] M_ASR = 2'd1;
  localparam logic [1:0] M_LSL = 2'd2;
  localparam logic [1:0] M_ROR = 2'd3;

  logic [1:0]       state, state_n;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] work, work_n;
  logic [SAW-1:0]   rem, eff, k;
  logic             capture;

  // Rotates wrap modulo WIDTH; the other modes saturate at WIDTH.
  always_comb begin
    eff = '0;
    if (mode == M_ROR)
      eff = SAW'(32'(shift_amount) % WIDTH);
    else if (32'(shift_amount) >= WIDTH)
      eff = SAW'(WIDTH);
    else
      eff = shift_amount;
  end

  // One iteration: shift by k = min(STEP, rem).
  always_comb begin
    k      = (32'(rem) < STEP) ? rem : SAW'(STEP);
    work_n = work;
    case (mode_q)
      M_LSR:   work_n = work >> k;
      M_ASR:   work_n = $unsigned($signed(work) >>> k);
      M_LSL:   work_n = work << k;
      default: work_n = (work >> k) | (work << (SAW'(WIDTH) - k));
    endcase
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (32'(rem) <= STEP) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          capture = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= '0;
      work     <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == SHIFT);
      done  <= (state_n == DONE);
      if (capture) begin
        work   <= data_in;
        rem    <= eff;
        mode_q <= mode;
      end else if (state == SHIFT) begin
        work <= work_n;
        rem  <= rem - k;
      end
      if (state == SHIFT && state_n == DONE) data_out <= work_n;
    end
  end

`ifdef SEQ_SHIFTER_CARRY_EN
  logic             last_q, last_n, over_q, zero_q;
  logic [WIDTH-1:0] shout;

  // Bit leaving the register on this iteration; held when nothing moves.
  always_comb begin
    shout  = '0;
    last_n = last_q;
    if (k != '0) begin
      if (mode_q == M_LSL)
        shout = work >> (SAW'(WIDTH) - k);
      else
        shout = work >> (k - SAW'(1));
      last_n = shout[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b0;
      over_q    <= 1'b0;
      zero_q    <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      if (capture) begin
        last_q <= 1'b0;
        over_q <= (mode != M_ROR) && (32'(shift_amount) > WIDTH);
        zero_q <= (shift_amount == '0);
      end else if (state == SHIFT) begin
        last_q <= last_n;
      end
      if (state == SHIFT && state_n == DONE) begin
        if (zero_q)
          carry_out <= 1'b0;
        else if (over_q)
          carry_out <= (mode_q == M_ASR) & work[WIDTH-1];
        else if (mode_q == M_ROR)
          carry_out <= work_n[WIDTH-1];
        else
          carry_out <= last_n;
      end
    end
  end
`else
  assign carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: a STEP=4 and a STEP=1 instance driven with directed and random operations.
module tb_seq_shifter;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start    [2];
  logic [1:0]  mode     [2];
  logic [31:0] din      [2];
  logic [5:0]  amt      [2];
  logic        busy     [2];
  logic        done     [2];
  logic [31:0] data_out [2];
  logic        carry_out[2];

  exp_t sb[2][$];
  int   bcnt[2];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]), .data_in(din[0]),
    .shift_amount(amt[0]), .busy(busy[0]), .done(done[0]),
    .data_out(data_out[0]), .carry_out(carry_out[0])
  );

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]), .data_in(din[1]),
    .shift_amount(amt[1]), .busy(busy[1]), .done(done[1]),
    .data_out(data_out[1]), .carry_out(carry_out[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-operand arithmetic straight from the shift rules.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] d,
                                 input int unsigned a, input int unsigned step);
    exp_t        r;
    logic [31:0] t;
    logic [63:0] dd;
    int unsigned eff;
    r.carry = 1'b0;
    case (m)
      2'd0: begin
        r.data = d >> a;
        t = d >> (a - 1);
        if (a != 0 && a <= 32) r.carry = t[0];
      end
      2'd1: begin
        r.data = $signed(d) >>> a;
        t = d >> (a - 1);
        if (a > 32) r.carry = d[31];
        else if (a != 0) r.carry = t[0];
      end
      2'd2: begin
        r.data = d << a;
        t = d >> (32 - a);
        if (a != 0 && a <= 32) r.carry = t[0];
      end
      default: begin
        dd = {d, d} >> (a % 32);
        r.data = dd[31:0];
        if (a != 0) r.carry = r.data[31];
      end
    endcase
`ifndef SEQ_SHIFTER_CARRY_EN
    r.carry = 1'b0;
`endif
    eff = (m == 2'd3) ? (a % 32) : ((a > 32) ? 32 : a);
    r.n = (eff == 0) ? 1 : int'((eff + step - 1) / step);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        bcnt[i] = 0;
      end else begin
        if (busy[i]) bcnt[i]++;
        if (done[i]) begin
          if (sb[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_done dut%0d: got done=1 expected no pulse at %0t", i, $time);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            check($sformatf("data_out dut%0d", i), data_out[i], e.data);
            check($sformatf("carry_out dut%0d", i), 32'(carry_out[i]), 32'(e.carry));
            check($sformatf("busy_cycles dut%0d", i), 32'(bcnt[i]), 32'(e.n));
          end
          bcnt[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] m, input logic [31:0] d, input int unsigned a);
    for (int c = 0; busy[i] && c < 200; c++) tick();
    if (busy[i]) check($sformatf("issue_wait dut%0d", i), 32'(busy[i]), 32'd0);
    start[i] = 1'b1;
    mode[i]  = m;
    din[i]   = d;
    amt[i]   = 6'(a);
    sb[i].push_back(model(m, d, a, (i == 0) ? 4 : 1));
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; !done[i] && c < 200; c++) tick();
    if (!done[i]) check($sformatf("done_timeout dut%0d", i), 32'(done[i]), 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || busy[0] || busy[1]) && c < 3000) begin
      tick();
      c++;
    end
    check("drain_outstanding", 32'(sb[0].size() + sb[1].size()), 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mode[i] = '0; din[i] = '0; amt[i] = '0;
    end
    rst = 1'b1;
    // start under reset must be overridden
    start[0] = 1'b1;
    tick(); tick();
    start[0] = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_busy dut%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("reset_done dut%0d", i), 32'(done[i]), 32'd0);
      check($sformatf("reset_data dut%0d", i), data_out[i], 32'd0);
      check($sformatf("reset_carry dut%0d", i), 32'(carry_out[i]), 32'd0);
    end

    issue(0, 2'd1, 32'h8000_0000, 4);
    wait_done(0);
    tick();
    issue(0, 2'd0, 32'hDEAD_BEEF, 40);
    issue(0, 2'd1, 32'h8000_0001, 63);
    issue(0, 2'd3, 32'h0000_0001, 33);
    issue(0, 2'd2, 32'h0000_0001, 31);
    // busy cycle 3: a competing start must be ignored
    tick(); tick();
    start[0] = 1'b1; mode[0] = 2'd0; din[0] = 32'hFFFF_FFFF; amt[0] = 6'd5;
    tick();
    start[0] = 1'b0;
    drain();

    // back-to-back: start in the DONE cycle
    issue(0, 2'd2, 32'h1234_5678, 0);
    wait_done(0);
    issue(0, 2'd0, 32'h1234_5678, 8);
    check("b2b_busy dut0", 32'(busy[0]), 32'd1);
    drain();

    // reset in busy cycle 2 aborts with no done pulse
    issue(0, 2'd0, 32'hFFFF_FFFF, 20);
    tick();
    rst = 1'b1;
    sb[0].delete();
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_data", data_out[0], 32'd0);
    repeat (12) tick();

    issue(1, 2'd1, 32'hF000_0000, 3);
    drain();

    for (int n = 0; n < 120; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      issue(i, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        wait_done(i);
        issue(i, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 63));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
